// File: rtl/game_controller.sv
// Mode sequencer for system_memory_v3: turns one-cycle host commands into
// correctly timed LOAD/RUN/OUTPUT strobes and qualifies the serial output.
module game_controller #(
    parameter int DATA_SIZE = 5,
    parameter int GEN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START_LOAD,
    input  logic                 START_RUN,
    input  logic [GEN_WIDTH-1:0] GEN_COUNT,
    input  logic                 START_OUTPUT,
    input  logic                 HOST_SERIAL_IN,
    input  logic                 HOST_VALID,
    output logic                 HOST_READY,
    input  logic                 MEM_SERIAL_OUT,
    output logic                 SERIAL_IN,
    output logic                 LOAD_MODE,
    output logic                 RUN_MODE,
    output logic                 OUTPUT_MODE,
    output logic                 OUT_DATA,
    output logic                 OUT_VALID,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int CW = $clog2(DATA_SIZE + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam logic [CW-1:0]        C_LAST  = CW'(DATA_SIZE - 1);
    localparam logic [CW-1:0]        C_DRAIN = CW'(DATA_SIZE);
    localparam logic [CW-1:0]        C_ONE   = CW'(1'b1);
    localparam logic [GEN_WIDTH-1:0] G_ONE   = GEN_WIDTH'(1'b1);

    logic [1:0]           r_state;
    logic [CW-1:0]        r_bit_cnt;
    logic [GEN_WIDTH-1:0] r_gen_cnt;
    logic                 r_run_mode;
    logic                 r_output_mode;
    logic                 r_out_valid;
    logic                 r_out_data;
    logic                 r_busy;
    logic                 r_done;

    logic [1:0]           w_state_nx;
    logic [CW-1:0]        w_bit_cnt_nx;
    logic [GEN_WIDTH-1:0] w_gen_cnt_nx;
    logic                 w_done_nx;
    logic                 w_accept;

    // Zero-latency load handshake: a bit is accepted and shifted on the same edge.
    assign w_accept    = (r_state == S_LOAD) && HOST_VALID;
    assign HOST_READY  = (r_state == S_LOAD);
    assign LOAD_MODE   = w_accept;
    assign SERIAL_IN   = HOST_SERIAL_IN;

    assign RUN_MODE    = r_run_mode;
    assign OUTPUT_MODE = r_output_mode;
    assign OUT_VALID   = r_out_valid;
    assign OUT_DATA    = r_out_data;
    assign BUSY        = r_busy;
    assign DONE        = r_done;

    // Next state and counters; RUN beats LOAD beats OUTPUT when starts collide.
    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_gen_cnt_nx = r_gen_cnt;
        w_done_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START_RUN) begin
                    if (GEN_COUNT == '0) begin
                        w_done_nx = 1'b1;
                    end else begin
                        w_state_nx   = S_RUN;
                        w_gen_cnt_nx = GEN_COUNT;
                    end
                end else if (START_LOAD) begin
                    w_state_nx   = S_LOAD;
                    w_bit_cnt_nx = '0;
                end else if (START_OUTPUT) begin
                    w_state_nx   = S_OUTPUT;
                    w_bit_cnt_nx = '0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_LOAD: begin
                if (HOST_VALID) begin
                    if (r_bit_cnt == C_LAST) begin
                        w_state_nx   = S_IDLE;
                        w_bit_cnt_nx = '0;
                        w_done_nx    = 1'b1;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + C_ONE;
                    end
                end else begin
                    w_bit_cnt_nx = r_bit_cnt;
                end
            end
            S_RUN: begin
                if (r_gen_cnt <= G_ONE) begin
                    w_state_nx   = S_IDLE;
                    w_gen_cnt_nx = '0;
                    w_done_nx    = 1'b1;
                end else begin
                    w_gen_cnt_nx = r_gen_cnt - G_ONE;
                end
            end
            S_OUTPUT: begin
                // Count DATA_SIZE shift cycles plus one drain cycle.
                if (r_bit_cnt == C_DRAIN) begin
                    w_state_nx   = S_IDLE;
                    w_bit_cnt_nx = '0;
                    w_done_nx    = 1'b1;
                end else begin
                    w_bit_cnt_nx = r_bit_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_bit_cnt_nx = '0;
                w_gen_cnt_nx = '0;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_gen_cnt     <= '0;
            r_run_mode    <= 1'b0;
            r_output_mode <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_bit_cnt     <= w_bit_cnt_nx;
            r_gen_cnt     <= w_gen_cnt_nx;
            r_run_mode    <= (w_state_nx == S_RUN);
            r_output_mode <= (w_state_nx == S_OUTPUT) && (w_bit_cnt_nx < C_DRAIN);
            r_out_valid   <= r_output_mode;
            r_out_data    <= MEM_SERIAL_OUT;
            r_busy        <= (w_state_nx != S_IDLE);
            r_done        <= w_done_nx;
        end
    end

endmodule
